// File: rtl/xadc_drp_sequencer.sv
// Periodic XADC DRP sweep over aux channels 6/7/14/15, holding the latest result per slot.
// Optional build macro XADC_SEQ_AVG_EN: each slot publishes the mean of four consecutive reads.
module xadc_drp_sequencer #(
  parameter int SAMPLE_DIV     = 1000000,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic [3:0]  chan_en,
  input  logic        err_clr,
  output logic        drp_den,
  output logic [6:0]  drp_daddr,
  input  logic        drp_drdy,
  input  logic [15:0] drp_do,
  output logic [63:0] sample,
  output logic        sample_valid,
  output logic [1:0]  sample_chan,
  output logic        sweep_done,
  output logic        busy,
  output logic        timeout_err,
  output logic        overrun,
  output logic [2:0]  dbg_state
);

  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_STORE = 3'd3,
    S_NEXT  = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_tick_cnt;
  logic [CW-1:0] r_to_cnt;
  logic [1:0]    r_ptr;
  logic [6:0]    r_daddr;
  logic          r_busy, r_timeout_err, r_overrun, r_fire;
  logic [15:0]   r_slot [4];
  logic [1:0]    w_first_ptr, w_next_ptr;
  logic          w_tick, w_any_en, w_next_found, w_timeout, w_capture;

  function automatic logic [6:0] slot_addr(input logic [1:0] s);
    case (s)
      2'd0:    slot_addr = 7'h16;
      2'd1:    slot_addr = 7'h17;
      2'd2:    slot_addr = 7'h1E;
      default: slot_addr = 7'h1F;
    endcase
  endfunction

  assign w_tick    = (r_tick_cnt == TW'(SAMPLE_DIV - 1));
  assign w_any_en  = |chan_en;
  assign w_capture = (r_state == S_WAIT) && drp_drdy;
  assign w_timeout = (r_state == S_WAIT) && !drp_drdy && (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Scan from the top down so the last hit is the lowest qualifying slot.
  always_comb begin
    w_first_ptr  = 2'd0;
    w_next_ptr   = r_ptr;
    w_next_found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (chan_en[i]) w_first_ptr = 2'(i);
      if (chan_en[i] && (3'(i) > {1'b0, r_ptr})) begin
        w_next_found = 1'b1;
        w_next_ptr   = 2'(i);
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset || w_tick) r_tick_cnt <= '0;
    else                 r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // DRP handshake: drp_den is a one-cycle request (ISSUE only); the single outstanding read
  // completes on the first drp_drdy seen in WAIT, and drdy outside WAIT is dropped.
  always_comb begin
    w_state_nxt  = r_state;
    drp_den      = 1'b0;
    sample_valid = 1'b0;
    sample_chan  = 2'd0;
    sweep_done   = 1'b0;
    case (r_state)
      S_IDLE:  if (w_tick && w_any_en) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        drp_den     = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (drp_drdy)       w_state_nxt = S_STORE;
        else if (w_timeout) w_state_nxt = S_NEXT;
      end
      S_STORE: begin
        sample_valid = r_fire;
        sample_chan  = r_ptr;
        w_state_nxt  = S_NEXT;
      end
      S_NEXT: begin
        if (w_next_found) w_state_nxt = S_ISSUE;
        else begin
          sweep_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_ptr    <= 2'd0;
      r_daddr  <= 7'd0;
      r_busy   <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_tick && w_any_en) begin
          r_ptr   <= w_first_ptr;
          r_daddr <= slot_addr(w_first_ptr);
          r_busy  <= 1'b1;
        end
        S_ISSUE: r_to_cnt <= '0;
        S_WAIT:  if (!drp_drdy && !w_timeout) r_to_cnt <= r_to_cnt + 1'b1;
        S_NEXT: begin
          if (w_next_found) begin
            r_ptr   <= w_next_ptr;
            r_daddr <= slot_addr(w_next_ptr);
          end else begin
            r_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_timeout_err <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_timeout)       r_timeout_err <= 1'b1;
      else if (err_clr)    r_timeout_err <= 1'b0;
      if (w_tick && r_busy) r_overrun    <= 1'b1;
      else if (err_clr)     r_overrun    <= 1'b0;
    end
  end

`ifdef XADC_SEQ_AVG_EN
  logic [17:0] r_acc [4];
  logic [1:0]  r_cnt [4];
  logic [17:0] w_acc_sum;

  assign w_acc_sum = r_acc[r_ptr] + {2'b00, drp_do};

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_slot[i] <= '0;
        r_acc[i]  <= '0;
        r_cnt[i]  <= '0;
      end
      r_fire <= 1'b0;
    end else if (w_capture) begin
      if (r_cnt[r_ptr] == 2'd3) begin
        r_slot[r_ptr] <= w_acc_sum[17:2];
        r_acc[r_ptr]  <= '0;
        r_cnt[r_ptr]  <= '0;
        r_fire        <= 1'b1;
      end else begin
        r_acc[r_ptr]  <= w_acc_sum;
        r_cnt[r_ptr]  <= r_cnt[r_ptr] + 2'd1;
        r_fire        <= 1'b0;
      end
    end else if (w_timeout) begin
      r_acc[r_ptr] <= '0;
      r_cnt[r_ptr] <= '0;
    end
  end
`else
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_slot[i] <= '0;
      r_fire <= 1'b0;
    end else if (w_capture) begin
      r_slot[r_ptr] <= drp_do;
      r_fire        <= 1'b1;
    end
  end
`endif

  assign drp_daddr   = r_daddr;
  assign sample      = {r_slot[3], r_slot[2], r_slot[1], r_slot[0]};
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign overrun     = r_overrun;
  assign dbg_state   = r_state;

endmodule

// File: doc/xadc_drp_sequencer.md
Name: xadc_drp_sequencer

Overview:
- Owns the XADC DRP read port and replaces the switch-selected single-address read.
- Divides CLK100MHZ into periodic sweep ticks and reads each enabled auxiliary channel (6, 7, 14, 15) in fixed order on every sweep.
- Holds the latest 16-bit result per channel for the LED bar, bin2dec/7-segment path and relay-trip logic.
- Flags DRP timeouts and sweep overruns.

Parameters:
- SAMPLE_DIV, 1000000: CLK100MHZ cycles between sweep ticks (10 ms default). Legal range is 16 and up.
- TIMEOUT_CYCLES, 64: cycles allowed from drp_den to drp_drdy before the read is abandoned.

Ports:
- CLK100MHZ  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- chan_en  in  4  per-slot enable; bit0 = aux6, bit1 = aux7, bit2 = aux14, bit3 = aux15.
- err_clr  in  1  single-cycle pulse that clears timeout_err and overrun.
- drp_den  out  1  DRP enable; one-cycle pulse.
- drp_daddr  out  7  DRP address.
- drp_drdy  in  1  DRP data ready, from the XADC.
- drp_do  in  16  DRP read data, from the XADC.
- sample  out  64  latest results; slot n occupies [16n+15:16n].
- sample_valid  out  1  one-cycle pulse when a slot is updated.
- sample_chan  out  2  slot index of the current sample_valid.
- sweep_done  out  1  one-cycle pulse at the end of each sweep.
- busy  out  1  high while a sweep is in progress.
- timeout_err  out  1  sticky; set on any DRP timeout.
- overrun  out  1  sticky; set when a tick arrives while busy.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Tick counter and timeout counter are 0.
  - Slot pointer is 0.
- Address map: slot 0 = 0x16, slot 1 = 0x17, slot 2 = 0x1E, slot 3 = 0x1F.
- Tick: a free-running counter counts 0 to SAMPLE_DIV-1 and wraps. The tick is asserted in the cycle the counter equals SAMPLE_DIV-1. The counter keeps running during sweeps.
- State machine, IDLE:
  - On a tick with chan_en != 0, load the pointer with the lowest enabled slot, set busy=1 and go to ISSUE.
  - On a tick with chan_en == 0, stay in IDLE; overrun is not set.
- State machine, ISSUE:
  - Drive drp_daddr to the slot address and drp_den=1 for exactly this one cycle.
  - Clear the timeout counter and go to WAIT.
- State machine, WAIT:
  - drp_daddr is held stable.
  - If drp_drdy=1, capture drp_do into the slot register and go to STORE.
  - Otherwise, if the counter has reached TIMEOUT_CYCLES-1, set timeout_err, leave the slot unchanged and go to NEXT.
  - Otherwise, increment the counter.
- State machine, STORE:
  - The slot register is already visible on sample.
  - Pulse sample_valid and drive sample_chan = pointer.
  - Go to NEXT.
- State machine, NEXT:
  - Advance the pointer to the next enabled slot above the current one and go to ISSUE.
  - If there is no higher enabled slot, pulse sweep_done, set busy=0 and go to IDLE.
- Latency:
  - Tick in cycle T gives drp_den in T+1.
  - drp_drdy in cycle D gives sample updated, sample_valid and sample_chan in D+1.
  - The next drp_den follows in D+3.
- chan_en is sampled at the tick for the first slot and at each NEXT for later slots. A slot disabled mid-sweep is skipped; its stored value is retained.
- drp_drdy is ignored in every state except WAIT, including a late drdy that arrives after a timeout.
- Tick while busy: the tick is dropped, overrun is set, and the sweep continues.
- Only one drp_den is outstanding at any time. drp_den is never asserted in WAIT.
- err_clr coinciding with a new error: the set wins.
- Reset mid-sweep: all outputs return to their reset values on the next edge, including clearing sample. No drp_den follows.

Optional Feature:
- Macro: XADC_SEQ_AVG_EN.
- When defined:
  - Each slot has an 18-bit accumulator and a 2-bit count.
  - Every captured read adds drp_do to the accumulator.
  - On the 4th read, the slot register takes accumulator[17:2], the accumulator and count clear, and sample_valid pulses. On reads 1 to 3, sample_valid stays low.
  - A timeout discards the partial accumulation for that slot.
  - Reset clears all accumulators.
- When undefined: every read updates the slot and pulses sample_valid, with no accumulator logic.

Test Plan:
- SAMPLE_DIV=100, chan_en=4'b1111, XADC model returns drdy 5 cycles after den with data 0x1000, 0x2000, 0x3000, 0x4000. Expect four den pulses at addresses 0x16, 0x17, 0x1E, 0x1F in order, four sample_valid pulses with chan 0..3, sample = 0x4000_3000_2000_1000, one sweep_done, busy low afterwards.
- chan_en=4'b1010. Expect only addresses 0x17 and 0x1F, sample_chan 1 then 3, and slots 0 and 2 still 0.
- Model withholds drdy for slot 1 with TIMEOUT_CYCLES=64. Expect timeout_err=1 64 cycles after that den, slot 1 unchanged, the sweep continuing to slot 2, and a late drdy ignored. Pulse err_clr and expect timeout_err=0.
- SAMPLE_DIV=16 with drdy latency 10. Expect a tick during busy, overrun=1 and the sweep completing normally; no extra den is issued.
- Assert reset while in WAIT. Expect drp_den, busy and sample all 0 on the next cycle. The subsequent drdy is ignored, and normal sweeps resume at the next tick.
- With XADC_SEQ_AVG_EN, reads of 0x0100, 0x0200, 0x0300, 0x0402 on slot 0. Expect a single sample_valid on the 4th read with slot 0 = 0x0280.
